// File: rtl/hazard_stall_unit.sv
// Purpose: load-use hazard detection with multi-cycle bubble insertion, memory-busy freeze and branch flush.
// Latency: all control outputs are combinational (zero cycles); o_stall_count updates on the next rising edge.
// Backpressure: i_mem_busy freezes the whole pipeline and stalls the bubble sequence without consuming bubbles.
//
// Ports:
//   i_clock, i_reset             rising-edge clock, synchronous active-high reset
//   i_instruction_rs/_rt         source registers of the instruction in IF/ID
//   i_uses_rt                    IF/ID instruction reads rt as a source
//   i_id_ex_rt, i_id_ex_MemRead  destination and load flag of the instruction in ID/EX
//   i_branch_taken               branch in ID resolved taken this cycle
//   i_mem_busy                   data memory not ready
//   o_PCWrite, o_if_id_write     PC / IF/ID write enables
//   o_control_mux                1 = zero the control word entering ID/EX (bubble)
//   o_if_id_flush                squash the fetched instruction
//   o_freeze                     hold ID/EX, EX/MEM, MEM/WB
//   o_stall_count                saturating count of bubble cycles since reset
module hazard_stall_unit #(
    parameter int unsigned NB_REG            = 5,
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned NB_STALL_CNT      = 16
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [NB_REG-1:0]       i_instruction_rs,
    input  logic [NB_REG-1:0]       i_instruction_rt,
    input  logic                    i_uses_rt,
    input  logic [NB_REG-1:0]       i_id_ex_rt,
    input  logic                    i_id_ex_MemRead,
    input  logic                    i_branch_taken,
    input  logic                    i_mem_busy,
    output logic                    o_PCWrite,
    output logic                    o_if_id_write,
    output logic                    o_control_mux,
    output logic                    o_if_id_flush,
    output logic                    o_freeze,
    output logic [NB_STALL_CNT-1:0] o_stall_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       hazard;
    logic       stall;
    logic       bubble;

    // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign hazard = i_id_ex_MemRead
                 && (i_id_ex_rt != '0)
                 && ((i_instruction_rs == i_id_ex_rt)
                     || (i_uses_rt && (i_instruction_rt == i_id_ex_rt)));

    // Once in STALL the remaining bubbles are committed; hazard inputs no longer matter.
    assign stall  = ((state == IDLE) && hazard) || (state == STALL);

    // A bubble is only spent when the pipeline actually advances.
    assign bubble = stall && !i_mem_busy;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= IDLE;
            cnt           <= '0;
            o_stall_count <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (bubble && (o_stall_count != {NB_STALL_CNT{1'b1}})) begin
                o_stall_count <= o_stall_count + {{(NB_STALL_CNT-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next-state: cnt holds the number of bubbles still owed after the current one.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!i_mem_busy) begin
            case (state)
                IDLE: begin
                    if (hazard && (LOAD_STALL_CYCLES > 1)) begin
                        state_nxt = STALL;
                        cnt_nxt   = 3'(LOAD_STALL_CYCLES - 1);
                    end
                end
                STALL: begin
                    cnt_nxt = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs: reset forces free-running pipeline; then memory freeze, then stall, then branch flush.
    always_comb begin
        o_PCWrite     = 1'b1;
        o_if_id_write = 1'b1;
        o_control_mux = 1'b0;
        o_if_id_flush = 1'b0;
        o_freeze      = 1'b0;
        if (!i_reset) begin
            if (i_mem_busy) begin
                o_freeze      = 1'b1;
                o_PCWrite     = 1'b0;
                o_if_id_write = 1'b0;
            end else if (stall) begin
                o_PCWrite     = 1'b0;
                o_if_id_write = 1'b0;
                o_control_mux = 1'b1;
            end else begin
                // A taken branch under stall/freeze is re-presented later, so flush only here.
                o_if_id_flush = i_branch_taken;
            end
        end
    end

endmodule
